// File: rtl/uart_pkg.sv
// Shared constants for the UART byte-stream transmitter: FSM encoding,
// frame geometry and the clocks-per-bit derivation.
`timescale 1ns/1ps
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W = 3;
  localparam int unsigned ST_W      = 3;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_START  = 3'd1;
  localparam logic [ST_W-1:0] ST_DATA   = 3'd2;
  localparam logic [ST_W-1:0] ST_PARITY = 3'd3;
  localparam logic [ST_W-1:0] ST_STOP   = 3'd4;

  // Integer division; callers must keep the result >= 2.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data.
// DEPTH must be a power of two; pointers wrap naturally.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Pointer and occupancy tracking; contents are discarded on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_full     = (r_level == LW'(DEPTH));
  assign o_empty    = (r_level == '0);
  assign o_level    = r_level;

endmodule

// File: rtl/uart_tx_stream.sv
// Byte-stream UART transmitter: buffers IO writes in a FIFO and sends them
// LSB first, back-to-back when more bytes are queued.
// Define UART_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
`timescale 1ns/1ps
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 27000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned PARITY_ODD  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          txd
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned LVL_W        = $clog2(FIFO_DEPTH) + 1;

  logic [ST_W-1:0]      r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [BIT_IDX_W-1:0] r_idx, w_idx_nxt, w_idx_inc;
  logic [7:0]           r_data, w_data_nxt;
  logic                 r_txd, w_txd_nxt;
  logic                 r_overflow;
  logic                 w_pop_c;
  logic                 w_bit_end;
  logic                 w_full;
  logic                 w_empty;
  logic [7:0]           w_pop_data;
  logic [LVL_W-1:0]     w_level;
  logic                 w_unused;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (wr_valid && wr_ready),
    .i_push_data(wr_data),
    .i_pop      (w_pop_c),
    .o_pop_data (w_pop_data),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (w_level)
  );

  assign w_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_idx_inc = r_idx + BIT_IDX_W'(1);

  // Next-state, bit timing and line value; every state change lands on a bit boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_txd_nxt   = r_txd;
    w_pop_c     = 1'b0;
    if (r_state != ST_IDLE) w_cnt_nxt = w_bit_end ? '0 : r_cnt + CNT_W'(1);
    case (r_state)
      ST_IDLE: begin
        w_txd_nxt = 1'b1;
        w_cnt_nxt = '0;
        if (!w_empty) begin
          w_pop_c     = 1'b1;
          w_data_nxt  = w_pop_data;
          w_txd_nxt   = 1'b0;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
          w_idx_nxt   = '0;
          w_txd_nxt   = r_data[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            w_state_nxt = ST_PARITY;
            w_txd_nxt   = (^r_data) ^ 1'(PARITY_ODD);
`else
            w_state_nxt = ST_STOP;
            w_txd_nxt   = 1'b1;
`endif
          end else begin
            w_idx_nxt = w_idx_inc;
            w_txd_nxt = r_data[w_idx_inc];
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = ST_STOP;
          w_txd_nxt   = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop_c     = 1'b1;
            w_data_nxt  = w_pop_data;
            w_txd_nxt   = 1'b0;
            w_state_nxt = ST_START;
          end else begin
            w_txd_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  // FSM, shift data and line registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

  // Sticky flag for writes dropped because the FIFO was full.
  always_ff @(posedge clk) begin
    if (rst) r_overflow <= 1'b0;
    else if (wr_valid && !wr_ready) r_overflow <= 1'b1;
  end

  assign wr_ready   = (w_level != LVL_W'(FIFO_DEPTH));
  assign busy       = (r_state != ST_IDLE) || (w_level != '0);
  assign overflow   = r_overflow;
  assign fifo_level = w_level;
  assign txd        = r_txd;

`ifdef UART_PARITY_EN
  assign w_unused = w_full;
`else
  assign w_unused = w_full ^ 1'(PARITY_ODD);
`endif

endmodule
